mult_unit: RTL and testbench

- Iterative RV32M multiplier in the EX stage; executes MUL, MULH, MULHSU and MULHU.
- Produces mult_ready, which the hazard unit uses to stall fetch/decode and bubble memory while a multiply in EX is unfinished.
- Consumes the pipeline's EX-advance and branch-flush signals so it knows when its result is taken or killed.

---
 rtl/common_types_pkg.sv | 23 ++
 rtl/mult_operand_cond.sv | 35 +++
 rtl/mult_unit.sv | 169 ++++++++++++++++
 tb/tb_mult_unit.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/common_types_pkg.sv
`default_nettype none
// ============================================================================
// Module      : common_types_pkg
// Description : Shared enums for the EX-stage multiplier (op codes, FSM states)
// Revision    : 1.0
// ============================================================================
package common_types_pkg;

    typedef enum logic [1:0] {
        MUL    = 2'd0,
        MULH   = 2'd1,
        MULHSU = 2'd2,
        MULHU  = 2'd3
    } mult_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } mult_state_t;

endpackage
`default_nettype wire

// File: rtl/mult_operand_cond.sv
`default_nettype none
// ============================================================================
// Module      : mult_operand_cond
// Description : Converts RV32M operands to unsigned magnitudes plus sign flag
// Revision    : 1.0
// ============================================================================
module mult_operand_cond
    import common_types_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic [XLEN-1:0] mag_a,
    output logic [XLEN-1:0] mag_b,
    output logic            neg
);

    mult_op_t w_op;
    logic     w_a_neg;
    logic     w_b_neg;

    // Negating 0x80000000 yields 0x80000000, which is the correct unsigned magnitude.
    always_comb begin
        w_op    = mult_op_t'(op);
        w_a_neg = a[XLEN-1] & ((w_op == MULH) || (w_op == MULHSU));
        w_b_neg = b[XLEN-1] & (w_op == MULH);
        mag_a   = w_a_neg ? -a : a;
        mag_b   = w_b_neg ? -b : b;
        neg     = w_a_neg ^ w_b_neg;
    end

endmodule
`default_nettype wire

// File: rtl/mult_unit.sv
`default_nettype none
// ============================================================================
// Module      : mult_unit
// Description : Iterative RV32M multiplier (MUL/MULH/MULHSU/MULHU) for EX stage.
//               Optional MULT_RESULT_REUSE_EN: reuse last product for MULH;MUL.
// Revision    : 1.0
// ============================================================================
module mult_unit
    import common_types_pkg::*;
#(
    parameter int BITS_PER_CYCLE = 2,
    parameter int XLEN           = 32
) (
    input  logic            clk,
    input  logic            nrst,
    input  logic            mult_en,
    input  logic            flush,
    input  logic            advance,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            ready,
    output logic            busy,
    output logic [XLEN-1:0] result
);

    localparam int STEPS = XLEN / BITS_PER_CYCLE;
    localparam int CW    = $clog2(STEPS) + 1;

    mult_state_t         r_state;
    mult_state_t         w_next;
    logic [2*XLEN-1:0]   r_acc;
    logic [2*XLEN-1:0]   r_mcand;
    logic [XLEN-1:0]     r_mplier;
    logic [CW-1:0]       r_cnt;
    logic                r_neg;
    logic [1:0]          r_op;
    logic [XLEN-1:0]     r_result;

    logic [XLEN-1:0]     w_mag_a;
    logic [XLEN-1:0]     w_mag_b;
    logic                w_neg;
    logic [2*XLEN-1:0]   w_pp;
    logic [2*XLEN-1:0]   w_acc_sum;
    logic [2*XLEN-1:0]   w_product;
    logic                w_start;
    logic                w_last;
    logic                w_hit;

    function automatic logic [XLEN-1:0] f_sel(input logic [1:0] o, input logic [2*XLEN-1:0] p);
        return (mult_op_t'(o) == MUL) ? p[XLEN-1:0] : p[2*XLEN-1:XLEN];
    endfunction

    mult_operand_cond #(.XLEN(XLEN)) u_cond (
        .op    (op),
        .a     (a),
        .b     (b),
        .mag_a (w_mag_a),
        .mag_b (w_mag_b),
        .neg   (w_neg)
    );

    always_comb begin
        w_pp = '0;
        for (int i = 0; i < BITS_PER_CYCLE; i++) begin
            if (r_mplier[i]) begin
                w_pp = w_pp + (r_mcand << i);
            end
        end
        w_acc_sum = r_acc + w_pp;
        w_product = r_neg ? -w_acc_sum : w_acc_sum;
    end

    assign w_start = (r_state == IDLE) && mult_en && !flush;
    assign w_last  = (r_state == BUSY) && (r_cnt == CW'(1)) && !flush;

`ifdef MULT_RESULT_REUSE_EN
    logic [XLEN-1:0]   r_cur_a;
    logic [XLEN-1:0]   r_cur_b;
    logic [XLEN-1:0]   r_last_a;
    logic [XLEN-1:0]   r_last_b;
    logic [1:0]        r_last_op;
    logic [2*XLEN-1:0] r_last_product;
    logic              r_reuse_valid;

    // The low word is sign-independent, so MUL may reuse a product of any op.
    assign w_hit = r_reuse_valid && (a == r_last_a) && (b == r_last_b) &&
                   ((mult_op_t'(op) == MUL) || (op == r_last_op));

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_cur_a        <= '0;
            r_cur_b        <= '0;
            r_last_a       <= '0;
            r_last_b       <= '0;
            r_last_op      <= '0;
            r_last_product <= '0;
            r_reuse_valid  <= 1'b0;
        end else begin
            if (w_start) begin
                r_cur_a <= a;
                r_cur_b <= b;
            end
            if (w_last) begin
                r_last_a       <= r_cur_a;
                r_last_b       <= r_cur_b;
                r_last_op      <= r_op;
                r_last_product <= w_product;
                r_reuse_valid  <= 1'b1;
            end
        end
    end
`else
    assign w_hit = 1'b0;
`endif

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (mult_en) w_next = w_hit ? DONE : BUSY;
            BUSY:    if (r_cnt == CW'(1)) w_next = DONE;
            DONE:    if (advance) w_next = IDLE;
            default: w_next = IDLE;
        endcase
        if (flush) w_next = IDLE;
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_cnt    <= '0;
            r_neg    <= 1'b0;
            r_op     <= '0;
            r_result <= '0;
        end else if (w_start) begin
            r_op     <= op;
            r_neg    <= w_neg;
            r_mcand  <= {{XLEN{1'b0}}, w_mag_a};
            r_mplier <= w_mag_b;
            r_acc    <= '0;
            r_cnt    <= CW'(STEPS);
`ifdef MULT_RESULT_REUSE_EN
            if (w_hit) r_result <= f_sel(op, r_last_product);
`endif
        end else if ((r_state == BUSY) && !flush) begin
            r_acc    <= w_acc_sum;
            r_mcand  <= r_mcand << BITS_PER_CYCLE;
            r_mplier <= r_mplier >> BITS_PER_CYCLE;
            r_cnt    <= r_cnt - CW'(1);
            if (r_cnt == CW'(1)) r_result <= f_sel(r_op, w_product);
        end
    end

    assign ready  = (r_state == DONE);
    assign busy   = (r_state == BUSY);
    assign result = r_result;

endmodule
`default_nettype wire

// File: tb/tb_mult_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_mult_unit
// Description : Scoreboard bench for mult_unit with directed RV32M vectors
// Revision    : 1.0
// ============================================================================
module tb_mult_unit;

    logic        clk     = 1'b0;
    logic        nrst    = 1'b0;
    logic        mult_en = 1'b0;
    logic        flush   = 1'b0;
    logic        advance = 1'b1;
    logic [1:0]  op      = 2'd0;
    logic [31:0] a       = '0;
    logic [31:0] b       = '0;
    logic        ready;
    logic        busy;
    logic [31:0] result;

`ifdef MULT_RESULT_REUSE_EN
    localparam int REUSE_LAT = 1;
`else
    localparam int REUSE_LAT = 17;
`endif

    always #5 clk = ~clk;

    mult_unit #(.BITS_PER_CYCLE(2), .XLEN(32)) dut (
        .clk     (clk),
        .nrst    (nrst),
        .mult_en (mult_en),
        .flush   (flush),
        .advance (advance),
        .op      (op),
        .a       (a),
        .b       (b),
        .ready   (ready),
        .busy    (busy),
        .result  (result)
    );

    typedef struct {
        logic [31:0] res;
        int          start;
        int          lat;
    } exp_t;

    exp_t q[$];
    exp_t m_e;
    int   checks = 0;
    int   passes = 0;
    int   cyc    = 0;
    logic prev_ready = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    // Monitor: every rising ready retires the oldest expected response.
    always @(negedge clk) begin
        if (nrst && ready && !prev_ready) begin
            if (q.size() == 0) begin
                checks++;
                $display("FAIL unexpected_ready: got ready=1 with result 0x%08h expected no pending op", result);
            end else begin
                m_e = q.pop_front();
                check("result", result, m_e.res);
                check("latency", 32'(cyc - m_e.start), 32'(m_e.lat));
            end
        end
        prev_ready = ready;
    end

    task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                          input logic [31:0] exp_res, input int lat, input int hold);
        exp_t e;
        bit   got;
        @(posedge clk); #1;
        op = o; a = x; b = y; mult_en = 1'b1; advance = (hold == 0);
        e.res = exp_res; e.start = cyc; e.lat = lat;
        q.push_back(e);
        got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(posedge clk); #1;
            if (ready) got = 1'b1;
        end
        if (!got) begin
            checks++;
            $display("FAIL ready_timeout: got no ready in 40 cycles expected ready after %0d", lat);
            void'(q.pop_back());
            mult_en = 1'b0;
            advance = 1'b1;
            return;
        end
        repeat (hold) begin
            @(posedge clk); #1;
            check("hold_ready", {31'b0, ready}, 32'd1);
            check("hold_result", result, exp_res);
        end
        advance = 1'b1;
        @(posedge clk); #1;
        mult_en = 1'b0;
        check("ready_drop", {31'b0, ready}, 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        int seen;
        #12;
        check("rst_ready", {31'b0, ready}, 32'd0);
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_result", result, 32'd0);
        @(posedge clk); #1;
        nrst = 1'b1;

        run_op(2'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 17, 0);
        run_op(2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, REUSE_LAT, 0);
        run_op(2'd0, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFEB, 17, 0);
        run_op(2'd1, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 17, 0);
        run_op(2'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 17, 0);
        run_op(2'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 17, 0);

        // Flush during BUSY aborts the multiply.
        @(posedge clk); #1;
        op = 2'd0; a = 32'd5; b = 32'd5; mult_en = 1'b1;
        repeat (5) @(posedge clk);
        #1 flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0; mult_en = 1'b0;
        check("flush_busy", {31'b0, busy}, 32'd0);
        check("flush_ready", {31'b0, ready}, 32'd0);
        seen = 0;
        repeat (20) begin
            @(posedge clk); #1;
            if (ready) seen++;
        end
        check("flush_no_ready", 32'(seen), 32'd0);

        // mult_en with flush in IDLE must not start.
        mult_en = 1'b1; flush = 1'b1;
        @(posedge clk); #1;
        mult_en = 1'b0; flush = 1'b0;
        check("flush_nostart", {31'b0, busy}, 32'd0);

        run_op(2'd0, 32'd6, 32'd7, 32'd42, 17, 0);
        run_op(2'd0, 32'd1000, 32'd1000, 32'h000F_4240, 17, 3);
        run_op(2'd1, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 17, 0);
        run_op(2'd0, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFEB, REUSE_LAT, 0);
        run_op(2'd3, 32'hFFFF_FFFD, 32'd7, 32'h0000_0006, 17, 0);

        // Asynchronous reset in the middle of BUSY.
        @(posedge clk); #1;
        op = 2'd0; a = 32'd3; b = 32'd3; mult_en = 1'b1;
        repeat (6) @(posedge clk);
        #3 nrst = 1'b0;
        #1;
        check("arst_ready", {31'b0, ready}, 32'd0);
        check("arst_busy", {31'b0, busy}, 32'd0);
        check("arst_result", result, 32'd0);
        mult_en = 1'b0;
        @(posedge clk); #1;
        nrst = 1'b1;

        run_op(2'd0, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFEB, 17, 0);

        repeat (3) @(posedge clk);
        check("queue_empty", 32'(q.size()), 32'd0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
`default_nettype wire
